// File: rtl/shared_adder_sched_pkg.sv
// Shared types and elaboration helpers for the time-multiplexed adder scheduler.
package shared_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        RESP
    } sched_state_e;

    localparam int unsigned DefNumReq = 4;

    // Requester id at the default requester count
    typedef logic [$clog2(DefNumReq)-1:0] req_id_t;

    // Number of adder slices needed to cover a W-bit operand
    function automatic int unsigned num_slices(int unsigned w, int unsigned slice_w);
        return w / slice_w;
    endfunction

    // Width of an index over n items; never narrower than one bit
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_adder_sched_if.sv
// Request/response bundle between the wide-arithmetic clients and the scheduler.
interface shared_adder_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 128
) ();
    import shared_adder_pkg::*;

    localparam int unsigned IdW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IdW-1:0]       rsp_id;
    logic [W-1:0]         rsp_sum;
    logic                 rsp_cout;
    logic                 busy;

    // Client side
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

endinterface

// File: rtl/shared_adder_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_gnt+1 with wrap.
module rr_arbiter
    import shared_adder_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdW = idx_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IdW-1:0] last_gnt,
    input  logic           enable,
    output logic [N-1:0]   gnt,
    output logic [IdW-1:0] gnt_id
);

    logic w_found;

    // First requester at increasing distance from the last grant wins
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (enable && !w_found && req[i] &&
                    (i == ((32'(last_gnt) + off) % N))) begin
                    w_found = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_id  = IdW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/shared_adder_sched.sv
// Time-multiplexes one SLICE_W-bit adder slice among NUM_REQ requesters of W-bit adds.
module shared_adder_sched
    import shared_adder_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 128,
    parameter int unsigned SLICE_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_adder_sched_if.slave  bus
);

    localparam int unsigned NSLICE = num_slices(W, SLICE_W);
    localparam int unsigned IdW    = idx_width(NUM_REQ);
    localparam int unsigned KW     = idx_width(NSLICE);

    if (W % SLICE_W != 0) begin : g_bad_slice
        $fatal(1, "shared_adder_sched: W must be a multiple of SLICE_W");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $fatal(1, "shared_adder_sched: NUM_REQ must be in 2..8");
    end

    sched_state_e   r_state, w_state_d;
    logic [IdW-1:0] r_last_gnt, w_last_gnt_d;
    logic [IdW-1:0] r_id, w_id_d;
    logic [KW-1:0]  r_k, w_k_d;
    logic           r_carry, w_carry_d;
    logic           r_cout, w_cout_d;
    logic [W-1:0]   r_op_a, w_op_a_d;
    logic [W-1:0]   r_op_b, w_op_b_d;
    logic [W-1:0]   r_sum, w_sum_d;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IdW-1:0]     w_gnt_id;
    logic               w_arb_en;
    logic [W-1:0]       w_sel_a, w_sel_b;
    logic [SLICE_W:0]   w_slice;

    // Grants only in IDLE and never while reset is asserted
    assign w_arb_en = rst_n && (r_state == IDLE);

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req      (bus.req_valid),
        .last_gnt (r_last_gnt),
        .enable   (w_arb_en),
        .gnt      (w_gnt),
        .gnt_id   (w_gnt_id)
    );

    // Operand mux driven by the one-hot grant
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = bus.req_a[i*W +: W];
                w_sel_b = bus.req_b[i*W +: W];
            end
        end
    end

    // Operands shift right each slice, so the active slice is always the low bits
    assign w_slice = {1'b0, r_op_a[SLICE_W-1:0]} + {1'b0, r_op_b[SLICE_W-1:0]}
                   + {{SLICE_W{1'b0}}, r_carry};

    // Next-state and datapath update
    always_comb begin
        w_state_d    = r_state;
        w_last_gnt_d = r_last_gnt;
        w_id_d       = r_id;
        w_k_d        = r_k;
        w_carry_d    = r_carry;
        w_cout_d     = r_cout;
        w_op_a_d     = r_op_a;
        w_op_b_d     = r_op_b;
        w_sum_d      = r_sum;
        unique case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_state_d    = COMPUTE;
                    w_op_a_d     = w_sel_a;
                    w_op_b_d     = w_sel_b;
                    w_id_d       = w_gnt_id;
                    w_last_gnt_d = w_gnt_id;
                    w_k_d        = '0;
                    w_carry_d    = 1'b0;
                end
            end
            COMPUTE: begin
                // New slice enters at the top; after NSLICE shifts the sum is aligned
                w_sum_d   = W'({w_slice[SLICE_W-1:0], r_sum} >> SLICE_W);
                w_op_a_d  = r_op_a >> SLICE_W;
                w_op_b_d  = r_op_b >> SLICE_W;
                w_carry_d = w_slice[SLICE_W];
                w_k_d     = r_k + KW'(1);
                if (r_k == KW'(NSLICE - 1)) begin
                    w_state_d = RESP;
                    w_cout_d  = w_slice[SLICE_W];
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= IdW'(NUM_REQ - 1);
            r_id       <= '0;
            r_k        <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_sum      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_last_gnt <= w_last_gnt_d;
            r_id       <= w_id_d;
            r_k        <= w_k_d;
            r_carry    <= w_carry_d;
            r_cout     <= w_cout_d;
            r_op_a     <= w_op_a_d;
            r_op_b     <= w_op_b_d;
            r_sum      <= w_sum_d;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_cout  = r_cout;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: doc/shared_adder_sched.md
Name: shared_adder_sched

Overview:
- Time-multiplexes one SLICE_W-bit adder slice between NUM_REQ requesters, each submitting W-bit a+b operations.
- Round-robin arbitration selects a requester; the block captures its operands and sequences the slice LSB-first over W/SLICE_W cycles, propagating carry.
- Result returns on a single valid/ready response port tagged with the requester id.
- Sits between the wide-arithmetic clients and the shared adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- W, 128, operand/result width
- SLICE_W, 32, adder slice width; W % SLICE_W == 0 checked at elaboration (fatal otherwise)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*W  packed operand A, requester i at [i*W +: W]
- req_b  in  NUM_REQ*W  packed operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  $clog2(NUM_REQ)  id of requester owning result
- rsp_sum  out  W  (a+b) mod 2^W
- rsp_cout  out  1  carry out of bit W-1
- busy  out  1  high in COMPUTE or RESP

Behaviour:
- Clock and reset: single clock clk; reset rst_n synchronous, active-low. While rst_n=0 at an edge:
  - state goes to IDLE.
  - rsp_valid, rsp_id, rsp_sum, rsp_cout and busy go to 0.
  - req_ready is 0 (combinational from state).
  - RR pointer last_gnt goes to NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-operation: any partial result is discarded, with no response.
- States: IDLE, COMPUTE, RESP.
- IDLE:
  - req_ready[g]=1 combinationally for the RR winner g among req_valid, searching from last_gnt+1 upward with wrap.
  - If any req_valid, at the edge: capture req_a[g] and req_b[g] into op regs; set id=g, last_gnt=g, slice index k=0, carry=0; go to COMPUTE.
  - Requester must hold a/b stable while valid and not ready; it may drop valid before a grant with no effect.
- COMPUTE:
  - req_ready all 0.
  - Each cycle compute {c, s} = a[k-slice] + b[k-slice] + carry (SLICE_W+1 bits).
  - Store s into sum[k*SLICE_W +: SLICE_W]; set carry=c; k++.
  - After slice NSLICE-1 (NSLICE=W/SLICE_W), go to RESP with rsp_cout = final carry.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_cout stay stable until rsp_ready=1 at an edge.
  - On that edge go to IDLE and clear rsp_valid.
  - req_ready all 0.
- Latency: request accepted at edge E0 → rsp_valid high after edge E0+NSLICE (4 cycles at defaults).
- Minimum initiation interval is NSLICE+2 cycles; there is no RESP→accept bypass.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 other transactions.
- Simultaneous events:
  - All req_valid high → grant order follows RR from last_gnt+1.
  - req_valid is ignored outside IDLE.
  - rsp_ready while not in RESP is ignored.
- Arithmetic: unsigned only; sum wraps mod 2^W; no saturation.

Decomposition:
- Package shared_adder_pkg holds:
  - localparam NSLICE derivation helper.
  - typedef enum logic [1:0] {IDLE, COMPUTE, RESP} sched_state_e.
  - typedef for id width.
- One sub-module, rr_arbiter #(N): inputs req[N], last_gnt, enable; outputs one-hot gnt and encoded gnt_id; purely combinational.
- The slice adder is inline (a single + expression).

Test Plan:
- Basic add: requester 0 sends a=10, b=15 → rsp_sum=25, rsp_cout=0, rsp_id=0, rsp_valid 4 cycles after accept.
- Second sequential op: a=5, b=65 → rsp_sum=70, rsp_cout=0.
- Carry chain: a=0xFFFF_FFFF, b=1 → rsp_sum=0x1_0000_0000, confirming carry crosses the slice boundary.
- Overflow wrap: a=2^128-1, b=1 → rsp_sum=0, rsp_cout=1.
- Contention: all four requesters valid continuously from reset with distinct operands → grants and rsp_id sequence 0,1,2,3,0; each sum is correct for its requester.
- Backpressure and reset:
  - rsp_ready held low for 5 cycles in RESP → rsp_valid, rsp_sum and rsp_id stable; req_ready all 0.
  - Separately, rst_n=0 in COMPUTE cycle 2 → next cycle IDLE, rsp_valid=0 and no response emitted.
  - Next request after reset is granted to requester 0 when all requesters are valid.
